rgmii_tx_ddr: RTL
=================

# rgmii_tx_ddr

Transmit half of the RGMII PHY interface: accepts a GMII byte stream from the MAC and drives 4-bit RGMII data, TX_CTL and TX_CLK with behavioural output-DDR registers. It supports 1000, 100 and 10 Mb/s, using a clock-enable handshake toward the MAC for the slower speeds. It sits between the Ethernet MAC TX path and the FPGA output pins, complementing the input-DDR capture on the receive side.

## Interface
- `DIV_100`, default 5: `clk` cycles per TX_CLK period at 100 Mb/s.
- `DIV_10`, default 50: `clk` cycles per TX_CLK period at 10 Mb/s.
- `clk`  in  1  125 MHz transmit clock; all logic on posedge, except the DDR fall path.
- `rst_n`  in  1  asynchronous, active-low reset.
- `speed`  in  2  2'b00 = 10M, 2'b01 = 100M, 2'b10 or 2'b11 = 1000M; synchronous to `clk`.
- `gmii_txd`  in  8  transmit byte.
- `gmii_tx_en`  in  1  frame valid.
- `gmii_tx_er`  in  1  transmit error.
- `gmii_clk_en`  out  1  byte-accept strobe to MAC.
- `rgmii_txd`  out  4  DDR data.
- `rgmii_tx_ctl`  out  1  DDR control.
- `rgmii_tx_clk`  out  1  forwarded clock; the 90° skew comes from the PHY or board.

## Operation
- Capture: in any cycle with `gmii_clk_en`=1, `gmii_txd`, `gmii_tx_en` and `gmii_tx_er` are registered at the closing posedge. The MAC holds them valid for that cycle.
- DDR output model:
  - Per bit, the rise value is registered at posedge.
  - The fall value is registered at posedge, then re-registered at negedge.
  - The pin shows the rise value while `clk` is high and the fall value while `clk` is low.
- 1000M mode:
  - `gmii_clk_en` is constantly 1.
  - Rise: `txd[3:0]` and `tx_en`. Fall: `txd[7:4]` and `tx_en^tx_er`.
  - TX_CLK rise=1, fall=0.
- 10/100 mode:
  - Counter `cnt` runs 0..DIV-1, where DIV = `DIV_100` or `DIV_10`.
  - A `phase` bit toggles at each wrap: 0 = low nibble, 1 = high nibble.
  - The nibble is held constant on both edges for the whole TX_CLK period.
  - CTL rise=`tx_en` and fall=`tx_en^tx_er` throughout both periods of a byte.
  - `gmii_clk_en`=1 for exactly one cycle, when `cnt`=DIV-1 and `phase`=1. The new byte is output from the next cycle, at `cnt`=0 and `phase`=0.
- TX_CLK in 10/100 mode:
  - Rise bit = (`cnt` < ceil(DIV/2)); fall bit = (`cnt` < floor(DIV/2)).
  - DIV=5 gives a 2.5-cycle high time; DIV=50 gives 25 cycles high and 25 low.
- Speed change: on a cycle where `speed` differs from its registered copy:
  - `cnt` and `phase` clear to 0.
  - The capture register clears to idle (`en`=0, `er`=0, `txd`=0).
  - `gmii_clk_en` is 0 in that cycle.
  - Any byte in flight is dropped. The MAC must only change speed between frames.
- Reset (asynchronous):
  - All registers clear.
  - `rgmii_txd`=0, `rgmii_tx_ctl`=0, `rgmii_tx_clk`=0, `gmii_clk_en`=0.
  - Behaviour is identical when reset is asserted mid-frame.

## Timing
- 1000M latency: a byte captured at posedge k is driven as the low nibble in the high phase after posedge k+1, and as the high nibble in the following low phase.
- 10/100 latency: a byte captured at posedge k has its low nibble on the pins from posedge k+1 for DIV cycles, then its high nibble for DIV cycles.
- First `gmii_clk_en` after reset deassertion:
  - 1000M: the first posedge after release.
  - 10/100: the cycle with `cnt`=DIV-1, `phase`=1, i.e. 2·DIV cycles after release.
- Byte interval: 1 cycle at 1000M, 2·DIV cycles at 10/100.

## Configuration
- `RGMII_TX_LOW_SPEED_EN`
  - Defined: the 10/100 logic described above is compiled in.
  - Undefined: `speed` is ignored and the block is gigabit only. `cnt` and `phase` are not built, `gmii_clk_en` is tied to 1 after reset, and the speed-change logic is absent.

## Test plan
- 1000M, bytes 0x5D,0xA3 with `tx_en`=1, `tx_er`=0 -> pins show 0xD,0x5,0x3,0xA on successive half-cycles; CTL 1,1,1,1; latency 1 cycle from capture.
- 1000M, byte 0x0F with `tx_en`=1, `tx_er`=1 -> CTL rise=1, fall=0 for that byte.
- 100M, DIV=5, byte 0x5D -> `gmii_clk_en` pulses every 10 cycles; `rgmii_txd`=0xD for 5 cycles, then 0x5 for 5 cycles; TX_CLK high 2.5 and low 2.5 cycles.
- 10M, DIV=50 -> `gmii_clk_en` period 100 cycles; TX_CLK high 25 and low 25 cycles; nibble stable for 50 cycles.
- `speed` 2'b10 -> 2'b01 mid-stream -> `cnt`/`phase` clear, CTL=0 from the next output cycle, first `gmii_clk_en` 10 cycles later.
- `rst_n` low mid-frame between clock edges -> all outputs 0 immediately; after release in 1000M, `gmii_clk_en`=1 after the first posedge.

Source files
------------

// File: rtl/rgmii_tx_ddr_if.sv
// GMII-side handshake and RGMII pin bundle for the RGMII transmit DDR stage.
// master = MAC/driver side, slave = rgmii_tx_ddr.
interface rgmii_tx_ddr_if;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       gmii_clk_en;
    logic [3:0] rgmii_txd;
    logic       rgmii_tx_ctl;
    logic       rgmii_tx_clk;

    modport master (
        output gmii_txd,
        output gmii_tx_en,
        output gmii_tx_er,
        input  gmii_clk_en,
        input  rgmii_txd,
        input  rgmii_tx_ctl,
        input  rgmii_tx_clk
    );

    modport slave (
        input  gmii_txd,
        input  gmii_tx_en,
        input  gmii_tx_er,
        output gmii_clk_en,
        output rgmii_txd,
        output rgmii_tx_ctl,
        output rgmii_tx_clk
    );
endinterface

// File: rtl/rgmii_tx_ddr.sv
// RGMII transmit path: GMII byte capture and behavioural output-DDR pins.
// Define RGMII_TX_LOW_SPEED_EN to add 10/100 Mb/s support; the default build is gigabit only.
module rgmii_tx_ddr #(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    speed,
    rgmii_tx_ddr_if.slave bus
);
    logic       run_q, run_d;
    logic [7:0] txd_q, txd_d;
    logic       en_q, en_d;
    logic       er_q, er_d;
    logic [3:0] d_rise_q, d_rise_d;
    logic [3:0] d_fpos_q, d_fpos_d;
    logic [3:0] d_fneg_q;
    logic       ctl_rise_q, ctl_rise_d;
    logic       ctl_fpos_q, ctl_fpos_d;
    logic       ctl_fneg_q;
    logic       ck_rise_q, ck_rise_d;
    logic       ck_fpos_q, ck_fpos_d;
    logic       ck_fneg_q;

    logic       clk_en;
    logic       clear_cap;
    logic       gig;
    logic       hi_nib;
    logic       ck_rise_slow;
    logic       ck_fall_slow;

`ifdef RGMII_TX_LOW_SPEED_EN
    localparam int DIV_MAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
    localparam int CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

    logic [1:0]       speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] half_hi;
    logic [CNT_W-1:0] half_lo;
    logic             wrap;

    // A speed change restarts the nibble timing and drops whatever byte was in flight.
    always_comb begin
        clear_cap = (speed != speed_q);
        gig       = speed_q[1];
        if (speed_q == 2'b01) begin
            div_m1  = CNT_W'(DIV_100 - 1);
            half_hi = CNT_W'((DIV_100 + 1) / 2);
            half_lo = CNT_W'(DIV_100 / 2);
        end else begin
            div_m1  = CNT_W'(DIV_10 - 1);
            half_hi = CNT_W'((DIV_10 + 1) / 2);
            half_lo = CNT_W'(DIV_10 / 2);
        end
        wrap         = (cnt_q == div_m1);
        clk_en       = run_q && !clear_cap && (gig || (wrap && phase_q));
        hi_nib       = phase_q;
        ck_rise_slow = (cnt_q < half_hi);
        ck_fall_slow = (cnt_q < half_lo);

        speed_d = speed;
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (clear_cap || gig) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q <= 2'b00;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
`else
    logic [1:0]  speed_unused;
    localparam int DIV_UNUSED = DIV_100 + DIV_10;

    assign speed_unused = speed;

    always_comb begin
        clear_cap    = 1'b0;
        gig          = 1'b1;
        clk_en       = run_q;
        hi_nib       = 1'b0;
        ck_rise_slow = 1'b1;
        ck_fall_slow = 1'b0;
    end
`endif

    // Gigabit splits the byte across both edges; 10/100 repeats one nibble on both edges.
    always_comb begin
        run_d = 1'b1;
        txd_d = txd_q;
        en_d  = en_q;
        er_d  = er_q;
        if (clear_cap) begin
            txd_d = 8'h00;
            en_d  = 1'b0;
            er_d  = 1'b0;
        end else if (clk_en) begin
            txd_d = bus.gmii_txd;
            en_d  = bus.gmii_tx_en;
            er_d  = bus.gmii_tx_er;
        end

        ctl_rise_d = en_q;
        ctl_fpos_d = en_q ^ er_q;
        if (gig) begin
            d_rise_d  = txd_q[3:0];
            d_fpos_d  = txd_q[7:4];
            ck_rise_d = 1'b1;
            ck_fpos_d = 1'b0;
        end else begin
            d_rise_d  = hi_nib ? txd_q[7:4] : txd_q[3:0];
            d_fpos_d  = d_rise_d;
            ck_rise_d = ck_rise_slow;
            ck_fpos_d = ck_fall_slow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            txd_q      <= 8'h00;
            en_q       <= 1'b0;
            er_q       <= 1'b0;
            d_rise_q   <= 4'h0;
            d_fpos_q   <= 4'h0;
            ctl_rise_q <= 1'b0;
            ctl_fpos_q <= 1'b0;
            ck_rise_q  <= 1'b0;
            ck_fpos_q  <= 1'b0;
        end else begin
            run_q      <= run_d;
            txd_q      <= txd_d;
            en_q       <= en_d;
            er_q       <= er_d;
            d_rise_q   <= d_rise_d;
            d_fpos_q   <= d_fpos_d;
            ctl_rise_q <= ctl_rise_d;
            ctl_fpos_q <= ctl_fpos_d;
            ck_rise_q  <= ck_rise_d;
            ck_fpos_q  <= ck_fpos_d;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_fneg_q   <= 4'h0;
            ctl_fneg_q <= 1'b0;
            ck_fneg_q  <= 1'b0;
        end else begin
            d_fneg_q   <= d_fpos_q;
            ctl_fneg_q <= ctl_fpos_q;
            ck_fneg_q  <= ck_fpos_q;
        end
    end

    assign bus.gmii_clk_en  = clk_en;
    assign bus.rgmii_txd    = clk ? d_rise_q : d_fneg_q;
    assign bus.rgmii_tx_ctl = clk ? ctl_rise_q : ctl_fneg_q;
    assign bus.rgmii_tx_clk = clk ? ck_rise_q : ck_fneg_q;
endmodule
